// File: rtl/pcileech_tlp_rx_framer.sv
// pcileech_tlp_rx_framer: store-and-forward TLP framer between the PCIe RX FIFO and the FT601 packetiser.
//
// Drains 32-bit dwords from a standard-mode FIFO into a single-TLP buffer. The header length
// is checked against the dwords actually received. Only complete, well-formed TLPs are replayed
// on a ready/valid stream. Malformed or oversized TLPs are dropped and counted.
//
// Optional feature macro: PCILEECH_TLP_RX_CPL_FILTER_EN
//   When defined, only Cpl/CplD TLPs are forwarded. Other well-formed TLPs are discarded and
//   counted on cnt_filt.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pcie_tlp_rx_data/last  FIFO read data and end-of-TLP flag (1 cycle after rd_en)
//   pcie_tlp_rx_valid      FIFO slot carries a real dword (padding slots have valid=0)
//   pcie_tlp_rx_empty      FIFO empty
//   pcie_tlp_rx_rd_en      FIFO read enable
//   tlp_out_data/last      forwarded dword and end-of-TLP flag
//   tlp_out_valid/ready    output handshake
//   cnt_ok, cnt_drop       saturating counts of forwarded and dropped TLPs
//   cnt_filt               saturating count of filtered TLPs (filter builds only)
//   busy                   a TLP is being filled or drained
module pcileech_tlp_rx_framer #(
    parameter int DEPTH_DW = 256,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcie_tlp_rx_data,
    input  logic             pcie_tlp_rx_last,
    input  logic             pcie_tlp_rx_valid,
    input  logic             pcie_tlp_rx_empty,
    output logic             pcie_tlp_rx_rd_en,
    output logic [31:0]      tlp_out_data,
    output logic             tlp_out_last,
    output logic             tlp_out_valid,
    input  logic             tlp_out_ready,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_drop,
`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
    output logic [CNT_W-1:0] cnt_filt,
`endif
    output logic             busy
);
    localparam int AW = $clog2(DEPTH_DW);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t        state, state_nx;
    logic [31:0]   mem [DEPTH_DW];
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, rd_addr;
    logic [10:0]   exp_len, hdr_len, cur_len;
    logic          ovf, full, in_dw, tlp_end, good, fwd, hs, done, load, ld_last;

    always_comb begin
        hdr_len = (pcie_tlp_rx_data[29] ? 11'd4 : 11'd3) +
                  (pcie_tlp_rx_data[30] ? ((pcie_tlp_rx_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, pcie_tlp_rx_data[9:0]}) : 11'd0);
        // a TLP whose header is also its last dword must be judged on the header just arriving
        cur_len = (count == '0) ? hdr_len : exp_len;
        full    = count == (AW+1)'(DEPTH_DW);
        in_dw   = (state == S_FILL) && pcie_tlp_rx_valid;
        tlp_end = in_dw && pcie_tlp_rx_last;
        // a dword arriving with the buffer full is the overflow itself, even if it is the last one
        good    = tlp_end && !ovf && !full && (32'(count) + 32'd1 == 32'(cur_len));
        hs      = tlp_out_valid && tlp_out_ready;
        done    = hs && tlp_out_last;
        // first load primes the output register; later loads refill it on each non-final handshake
        load    = (state == S_DRAIN) && (!tlp_out_valid || (hs && !tlp_out_last));
        rd_addr = tlp_out_valid ? rd_ptr : '0;
        ld_last = ({1'b0, rd_addr} + (AW+1)'(1)) == count;
    end

`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
    logic is_cpl, cpl_now;

    always_comb begin
        cpl_now = (count == '0) ? (pcie_tlp_rx_data[28:24] == 5'b01010) : is_cpl;
        fwd     = good && cpl_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_cpl   <= 1'b0;
            cnt_filt <= '0;
        end else begin
            if (in_dw && count == '0) is_cpl <= pcie_tlp_rx_data[28:24] == 5'b01010;
            if (good && !cpl_now && !(&cnt_filt)) cnt_filt <= cnt_filt + CNT_W'(1);
        end
    end
`else
    always_comb fwd = good;
`endif

    always_comb begin
        state_nx          = (state == S_FILL) ? (fwd ? S_DRAIN : S_FILL) : (done ? S_FILL : S_DRAIN);
        // never read in the cycle that returns a last dword, so nothing is in flight on entering drain
        pcie_tlp_rx_rd_en = !rst && (state == S_FILL) && !pcie_tlp_rx_empty && !(pcie_tlp_rx_valid && pcie_tlp_rx_last);
        busy              = (state != S_FILL) || (count != '0);
    end

    always_ff @(posedge clk) state <= rst ? S_FILL : state_nx;

    always_ff @(posedge clk)
        if (in_dw && !full) mem[count[AW-1:0]] <= pcie_tlp_rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            ovf           <= 1'b0;
            exp_len       <= '0;
            rd_ptr        <= '0;
            tlp_out_data  <= '0;
            tlp_out_last  <= 1'b0;
            tlp_out_valid <= 1'b0;
            cnt_ok        <= '0;
            cnt_drop      <= '0;
        end else begin
            if (in_dw) begin
                if (count == '0) exp_len <= hdr_len;
                if (tlp_end && !fwd) begin
                    count <= '0;
                    ovf   <= 1'b0;
                end else if (full) ovf <= 1'b1;
                else count <= count + (AW+1)'(1);
            end
            if (tlp_end && !good && !(&cnt_drop)) cnt_drop <= cnt_drop + CNT_W'(1);
            if (load) begin
                tlp_out_data  <= mem[rd_addr];
                tlp_out_last  <= ld_last;
                tlp_out_valid <= 1'b1;
                rd_ptr        <= rd_addr + AW'(1);
            end else if (done) begin
                tlp_out_valid <= 1'b0;
                count         <= '0;
                if (!(&cnt_ok)) cnt_ok <= cnt_ok + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pcileech_tlp_rx_framer.sv
// tb_pcileech_tlp_rx_framer: table-driven bench for pcileech_tlp_rx_framer with a FIFO model and output scoreboard.
`timescale 1ns/1ps
module tb_pcileech_tlp_rx_framer;
    localparam int DEPTH_DW = 8;
    localparam int CNT_W    = 3;
    localparam int SAT      = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcie_tlp_rx_data = '0;
    logic        pcie_tlp_rx_last = 1'b0;
    logic        pcie_tlp_rx_valid = 1'b0;
    logic        pcie_tlp_rx_empty;
    logic        pcie_tlp_rx_rd_en;
    logic [31:0] tlp_out_data;
    logic        tlp_out_last;
    logic        tlp_out_valid;
    logic        tlp_out_ready = 1'b1;
    logic [CNT_W-1:0] cnt_ok, cnt_drop;
`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
    logic [CNT_W-1:0] cnt_filt;
`endif
    logic        busy;

    pcileech_tlp_rx_framer #(.DEPTH_DW(DEPTH_DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pcie_tlp_rx_data(pcie_tlp_rx_data), .pcie_tlp_rx_last(pcie_tlp_rx_last),
        .pcie_tlp_rx_valid(pcie_tlp_rx_valid), .pcie_tlp_rx_empty(pcie_tlp_rx_empty),
        .pcie_tlp_rx_rd_en(pcie_tlp_rx_rd_en),
        .tlp_out_data(tlp_out_data), .tlp_out_last(tlp_out_last),
        .tlp_out_valid(tlp_out_valid), .tlp_out_ready(tlp_out_ready),
        .cnt_ok(cnt_ok), .cnt_drop(cnt_drop),
`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
        .cnt_filt(cnt_filt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic last; logic valid; } fent_t;
    fent_t fifo_mem [4096];
    int    fifo_wr = 0, fifo_rd = 0;
    logic  gap = 1'b0;
    int    rdy_mode = 0;
    bit    gap_en = 0;

    assign pcie_tlp_rx_empty = (fifo_rd == fifo_wr) || gap;

    // standard-mode FIFO: entry appears one cycle after rd_en
    always @(posedge clk) begin
        if (pcie_tlp_rx_rd_en && fifo_rd != fifo_wr) begin
            pcie_tlp_rx_data  <= fifo_mem[fifo_rd].data;
            pcie_tlp_rx_last  <= fifo_mem[fifo_rd].last;
            pcie_tlp_rx_valid <= fifo_mem[fifo_rd].valid;
            fifo_rd           <= fifo_rd + 1;
        end else begin
            pcie_tlp_rx_last  <= 1'b0;
            pcie_tlp_rx_valid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        tlp_out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        gap = gap_en && ($urandom_range(0, 3) == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] rx_q[$], exp_q[$];
    int    last_in_cyc = 0, rise_cyc = 0, stall_err = 0;
    bit    mon_off = 0;
    logic  pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (mon_off || rst) pv = 1'b0;
        else begin
            if (pv && !pr && (!tlp_out_valid || tlp_out_data != pd || tlp_out_last != pl)) stall_err++;
            if (pcie_tlp_rx_valid && pcie_tlp_rx_last) last_in_cyc = cyc;
            if (tlp_out_valid && !pv) rise_cyc = cyc;
            if (tlp_out_valid && tlp_out_ready) rx_q.push_back({tlp_out_last, tlp_out_data});
            pv = tlp_out_valid;
            pr = tlp_out_ready;
            pd = tlp_out_data;
            pl = tlp_out_last;
        end
    end

    int checks = 0, errors = 0;
    int m_ok = 0, m_drop = 0, m_filt = 0;
    int tlp_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return v > SAT ? SAT : v;
    endfunction

    task automatic push_tlp(input logic [31:0] dw0, input int n, input bit pad, input bit fwd);
        logic [31:0] d;
        tlp_id++;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? dw0 : 32'hD000_0000 + 32'(tlp_id << 8) + 32'(i);
            fifo_mem[fifo_wr] = {d, i == n - 1, 1'b1};
            fifo_wr++;
            if (fwd) exp_q.push_back({i == n - 1, d});
        end
        if (pad) begin
            fifo_mem[fifo_wr] = {32'hDEAD_BEEF, 1'b1, 1'b0};
            fifo_wr++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(fifo_rd == fifo_wr && !busy && !pcie_tlp_rx_valid && !tlp_out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s/idle: got timeout after %0d cycles expected idle", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic compare(input string name, input bit fwd);
        check($sformatf("%s/ndw", name), 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s/dw%0d", name, i), 64'(rx_q[i]), 64'(exp_q[i]));
        if (fwd) check($sformatf("%s/latency", name), 64'(rise_cyc - last_in_cyc), 64'd2);
        check($sformatf("%s/cnt_ok", name), 64'(cnt_ok), 64'(sat(m_ok)));
        check($sformatf("%s/cnt_drop", name), 64'(cnt_drop), 64'(sat(m_drop)));
`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
        check($sformatf("%s/cnt_filt", name), 64'(cnt_filt), 64'(sat(m_filt)));
`endif
        rx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        string       name;
        logic [31:0] dw0;
        int          n;
        bit          pad;
        bit          gaps;
        int          rdy;
        bit          good;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [31:0] dw0, input int n,
                                input bit pad, input bit gaps, input int rdy, input bit good);
        vec_t v;
        v.name = nm; v.dw0 = dw0; v.n = n; v.pad = pad; v.gaps = gaps; v.rdy = rdy; v.good = good;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        bit fwd;
        int n;
        vt.push_back(mk("cpld_3dw_len1",  32'h4A00_0001,  4, 1, 0, 0, 1));
        vt.push_back(mk("mwr_4dw_short",  32'h6000_0002,  5, 1, 0, 0, 0));
        vt.push_back(mk("mwr_4dw_len2",   32'h6000_0002,  6, 1, 1, 0, 1));
        vt.push_back(mk("mwr_depth_full", 32'h6000_0004,  8, 1, 1, 0, 1));
        vt.push_back(mk("cpld_len16_ovf", 32'h4A00_0010, 19, 1, 0, 0, 0));
        vt.push_back(mk("mrd_3dw",        32'h0000_0001,  3, 0, 1, 0, 1));
        vt.push_back(mk("mrd_4dw",        32'h2000_0000,  4, 1, 0, 0, 1));
        vt.push_back(mk("cpl_nodata",     32'h0A00_0000,  3, 1, 1, 0, 1));
        vt.push_back(mk("single_dw",      32'h4A00_0001,  1, 1, 0, 0, 0));
        vt.push_back(mk("cpld_len0",      32'h4A00_0000,  4, 1, 0, 0, 0));
        vt.push_back(mk("cpld_rand_rdy",  32'h4A00_0004,  7, 1, 1, 2, 1));
        vt.push_back(mk("cpld_depth_p1",  32'h4A00_0006,  9, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) vt.push_back(mk($sformatf("drop_sat%0d", i), 32'h4A00_0001, 1, 1, 0, 0, 0));
        vt.push_back(mk("cpld_ok_sat",    32'h4A00_0001,  4, 1, 1, 0, 1));

        repeat (3) @(negedge clk);
        check("rst/rd_en", 64'(pcie_tlp_rx_rd_en), 0);
        check("rst/valid", 64'(tlp_out_valid), 0);
        check("rst/data", 64'(tlp_out_data), 0);
        check("rst/last", 64'(tlp_out_last), 0);
        check("rst/cnt_ok", 64'(cnt_ok), 0);
        check("rst/cnt_drop", 64'(cnt_drop), 0);
        check("rst/busy", 64'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[k]) begin
`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
            fwd = vt[k].good && (vt[k].dw0[28:24] == 5'b01010);
`else
            fwd = vt[k].good;
`endif
            if (fwd) m_ok++;
            else if (vt[k].good) m_filt++;
            else m_drop++;
            rdy_mode = vt[k].rdy;
            gap_en = vt[k].gaps;
            push_tlp(vt[k].dw0, vt[k].n, vt[k].pad, fwd);
            wait_idle(vt[k].name);
            compare(vt[k].name, fwd);
        end
        rdy_mode = 0;
        gap_en = 0;

        // reset while a TLP is stalled in drain
        rdy_mode = 1;
        push_tlp(32'h4A00_0004, 7, 1, 0);
        n = 0;
        while (!tlp_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst/drain_started", 64'(tlp_out_valid), 1);
        repeat (3) @(negedge clk);
        check("mid_rst/stalled_valid", 64'(tlp_out_valid), 1);
        check("mid_rst/stalled_data", 64'(tlp_out_data), 64'h4A00_0004);
        mon_off = 1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst/valid", 64'(tlp_out_valid), 0);
        check("mid_rst/data", 64'(tlp_out_data), 0);
        check("mid_rst/last", 64'(tlp_out_last), 0);
        check("mid_rst/cnt_ok", 64'(cnt_ok), 0);
        check("mid_rst/cnt_drop", 64'(cnt_drop), 0);
        check("mid_rst/busy", 64'(busy), 0);
        check("mid_rst/rd_en", 64'(pcie_tlp_rx_rd_en), 0);
`ifdef PCILEECH_TLP_RX_CPL_FILTER_EN
        check("mid_rst/cnt_filt", 64'(cnt_filt), 0);
`endif
        rst = 1'b0;
        m_ok = 0; m_drop = 0; m_filt = 0;
        rx_q.delete();
        exp_q.delete();
        rdy_mode = 0;
        @(negedge clk);
        mon_off = 0;
        m_ok++;
        push_tlp(32'h4A00_0004, 7, 1, 1);
        wait_idle("post_rst");
        compare("post_rst", 1);

        check("stall_hold", 64'(stall_err), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcileech_tlp_rx_framer.md
Name: pcileech_tlp_rx_framer

Overview:
- Store-and-forward reader on the 32-bit TLP receive stream. It sits after the PCIe-core receive FIFO and before the FT601 packetiser.
- Drains dwords from the FIFO read port into a single-TLP buffer and checks the header length against the actual dword count.
- Forwards only complete, well-formed TLPs on a ready/valid 32-bit stream. Malformed and oversized TLPs are dropped and counted.

Parameters:
- DEPTH_DW, 256, buffer depth in dwords; a TLP longer than this is dropped (power of two, >=8).
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  100MHz clock
- rst  in  1  reset, synchronous, active-high
- pcie_tlp_rx_data  in  32  FIFO read data
- pcie_tlp_rx_last  in  1  dword is last in TLP
- pcie_tlp_rx_valid  in  1  read data valid; slot carries a real dword
- pcie_tlp_rx_empty  in  1  FIFO empty
- pcie_tlp_rx_rd_en  out  1  FIFO read enable
- tlp_out_data  out  32  forwarded dword
- tlp_out_last  out  1  last dword of forwarded TLP
- tlp_out_valid  out  1  output valid
- tlp_out_ready  in  1  downstream ready
- cnt_ok  out  CNT_W  TLPs forwarded, saturating
- cnt_drop  out  CNT_W  TLPs dropped (length mismatch or overflow), saturating
- busy  out  1  state != S_FILL or dword count != 0

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high.
- Reset values: all outputs 0, state S_FILL, dword count 0. Reset mid-TLP discards buffer contents; counters are cleared.

- FIFO read port:
  - Standard-mode FIFO: data, last and valid appear 1 cycle after rd_en.
  - rd_en = (state==S_FILL) & ~empty & ~(valid & last).
  - Result: no read is ever issued in the cycle that returns a TLP's last dword.
  - Sustained rate is 1 dword per clk.

- Entry qualification:
  - An entry with valid=0 is discarded regardless of last. This covers padding slots and idle cycles.
  - Only valid=1 entries are counted or stored.

- S_FILL:
  - First valid dword is header DW0.
  - Expected length = (DW0[29] ? 4 : 3) + (DW0[30] ? (DW0[9:0]==0 ? 1024 : DW0[9:0]) : 0). Use 11-bit arithmetic.
  - Each valid dword is written to buffer[count], then count increments.
  - If count reaches DEPTH_DW, set the overflow flag. Further dwords are read and not stored, until last.
  - On a valid dword with last=1:
    - If ~overflow and count+1 == expected: go to S_DRAIN.
    - Otherwise: cnt_drop++, clear count and flag, stay in S_FILL.

- S_DRAIN:
  - Buffer uses synchronous-read RAM with 1-entry prefetch into the output register.
  - tlp_out_valid rises 2 clk after the last dword's valid cycle.
  - Data and last are held stable while valid & ~ready.
  - One dword advances per cycle with valid & ready. ready held high gives back-to-back dwords.
  - tlp_out_last=1 on dword index count-1.
  - On the last handshake: cnt_ok++, count=0, go to S_FILL. rd_en may assert the next cycle.

- Counters saturate at all-ones and never wrap.
- Single TLP of 1 dword (count 1 != expected >=3) is dropped.
- Throughput: FILL and DRAIN are not overlapped. This is accepted.

Optional Feature:
- Macro: PCILEECH_TLP_RX_CPL_FILTER_EN.
- Defined:
  - The TLP is forwarded only if DW0[28:24]==5'b01010 (Cpl/CplD). All other well-formed TLPs are dropped silently.
  - Adds output cnt_filt [CNT_W] (saturating), incremented once per filtered TLP at its last dword.
  - Filtered TLPs do not touch cnt_drop.
- Undefined: all well-formed TLPs are forwarded; cnt_filt port absent.

Test Plan:
- CplD, 3DW hdr, length=1 (4 dwords, last on dword 4), ready=1 -> identical 4 dwords out, last on 4th, valid 2 clk after input last, cnt_ok=1.
- MWr 4DW hdr length=2 but last asserted on dword 5 -> nothing output, cnt_drop=1; next good TLP forwarded normally.
- Padding entry (valid=0, last=1) after each TLP and random empty gaps -> padding never stored, output unaffected.
- DEPTH_DW=8, TLP with length=16 -> all 19 dwords read from FIFO, none output, cnt_drop=1, state returns to S_FILL.
- Random ready toggling during drain of a 3DW+4-dword TLP -> data/last stable while stalled, exactly 7 handshakes; rst asserted mid-drain -> outputs 0 next clk, subsequent TLP forwarded intact.
- With PCILEECH_TLP_RX_CPL_FILTER_EN: MRd (DW0[28:24]=0) then CplD -> only CplD out, cnt_filt=1, cnt_ok=1, cnt_drop=0.
